// File: rtl/dice_pkg.sv
// Shared definitions for the dice display: FSM state encoding, legal face
// range, and the pip patterns driven onto the 7-LED display.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SETTLE  = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;

  // led bit order: 0 TL, 1 TR, 2 ML, 3 C, 4 MR, 5 BL, 6 BR
  localparam logic [6:0] PIP_1   = 7'b0001000;
  localparam logic [6:0] PIP_2   = 7'b1000001;
  localparam logic [6:0] PIP_3   = 7'b1001001;
  localparam logic [6:0] PIP_4   = 7'b1100011;
  localparam logic [6:0] PIP_5   = 7'b1101011;
  localparam logic [6:0] PIP_6   = 7'b1110111;
  localparam logic [6:0] PIP_INV = 7'b1111111;

  // True when the counter value is a real die face (1..6).
  function automatic logic is_face(input logic [2:0] f);
    return (f >= FACE_MIN) && (f <= FACE_MAX);
  endfunction

endpackage

// File: rtl/dice_if.sv
// Connection between the dice counter / button side (master) and the
// display block (slave). Clock and reset are kept as plain ports.
interface dice_if #(
  parameter int CNT_W = 8
);
  logic             button;
  logic [2:0]       throw;
  logic [6:0]       led;
  logic [2:0]       result;
  logic             result_valid;
  logic             result_err;
  logic [CNT_W-1:0] roll_count;
  logic [47:0]      face_hist;

  modport master (
    output button, throw,
    input  led, result, result_valid, result_err, roll_count, face_hist
  );

  modport slave (
    input  button, throw,
    output led, result, result_valid, result_err, roll_count, face_hist
  );
endinterface

// File: rtl/dice_pip_decoder.sv
// Combinational face-to-pip decoder. Anything outside 1..6 lights every LED
// so a broken counter is obvious on the board.
module dice_pip_decoder
  import dice_pkg::*;
(
  input  logic [2:0] throw,
  output logic [6:0] led
);

  // Look up the pip pattern for the current face value.
  always_comb begin
    led = PIP_INV;
    case (throw)
      3'd1:    led = PIP_1;
      3'd2:    led = PIP_2;
      3'd3:    led = PIP_3;
      3'd4:    led = PIP_4;
      3'd5:    led = PIP_5;
      3'd6:    led = PIP_6;
      default: led = PIP_INV;
    endcase
  end

endmodule

// File: rtl/dice_display.sv
// Electronic-dice display controller. Animates the pips while the button is
// held, waits a settle window after release, then latches and holds the
// final face together with a valid/error flag and a saturating throw count.
// Optional per-face histogram enabled with macro DICE_STATS_EN.
module dice_display
  import dice_pkg::*;
#(
  parameter int ROLL_DIV      = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic   clk,
  input  logic   rst,
  dice_if.slave  dif
);

  localparam int DIV_W = (ROLL_DIV > 1) ? $clog2(ROLL_DIV) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ROLL_DIV - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic [SET_W-1:0] settle_r;
  logic [6:0]       led_r;
  logic [2:0]       result_r;
  logic             result_valid_r;
  logic             result_err_r;
  logic [CNT_W-1:0] roll_count_r;

  logic [6:0]       pip_s;
  logic             face_ok_s;
  logic             latch_s;

  dice_pip_decoder u_pip (
    .throw (dif.throw),
    .led   (pip_s)
  );

  assign face_ok_s = is_face(dif.throw);

  // The result is captured on the last settle cycle if the button stays up.
  assign latch_s = (state_r == SETTLE) && !dif.button && (settle_r == SET_LAST);

  // Main FSM: roll animation, settle window, latch and hold of the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      div_r          <= '0;
      settle_r       <= '0;
      led_r          <= 7'd0;
      result_r       <= 3'd0;
      result_valid_r <= 1'b0;
      result_err_r   <= 1'b0;
      roll_count_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          led_r <= 7'd0;
          if (dif.button) begin
            state_r <= ROLLING;
            div_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end

        ROLLING: begin
          result_valid_r <= 1'b0;
          result_err_r   <= 1'b0;
          // Refresh the animation once per divider period.
          if (div_r == '0) begin
            led_r <= pip_s;
          end else begin
            led_r <= led_r;
          end
          if (div_r == DIV_LAST) begin
            div_r <= '0;
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
          if (!dif.button) begin
            state_r  <= SETTLE;
            settle_r <= '0;
          end else begin
            state_r <= ROLLING;
          end
        end

        SETTLE: begin
          if (dif.button) begin
            // Re-press abandons this throw; animation restarts immediately.
            state_r  <= ROLLING;
            settle_r <= '0;
            div_r    <= '0;
          end else if (latch_s) begin
            state_r        <= SHOW;
            result_r       <= dif.throw;
            led_r          <= pip_s;
            result_valid_r <= 1'b1;
            result_err_r   <= !face_ok_s;
            if (roll_count_r != CNT_MAX) begin
              roll_count_r <= roll_count_r + CNT_W'(1);
            end else begin
              roll_count_r <= roll_count_r;
            end
          end else begin
            settle_r <= settle_r + SET_W'(1);
          end
        end

        SHOW: begin
          if (dif.button) begin
            // result itself is kept until the next latch.
            state_r        <= ROLLING;
            div_r          <= '0;
            result_valid_r <= 1'b0;
            result_err_r   <= 1'b0;
          end else begin
            state_r <= SHOW;
          end
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef DICE_STATS_EN
  logic [7:0] hist_r [6];

  // Per-face saturating histogram, bumped alongside roll_count on good latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        hist_r[i] <= 8'd0;
      end
    end else if (latch_s && face_ok_s) begin
      for (int i = 0; i < 6; i++) begin
        if ((dif.throw == 3'(i + 1)) && (hist_r[i] != 8'hFF)) begin
          hist_r[i] <= hist_r[i] + 8'd1;
        end else begin
          hist_r[i] <= hist_r[i];
        end
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        hist_r[i] <= hist_r[i];
      end
    end
  end

  assign dif.face_hist = {hist_r[5], hist_r[4], hist_r[3],
                          hist_r[2], hist_r[1], hist_r[0]};
`else
  assign dif.face_hist = 48'd0;
`endif

  assign dif.led          = led_r;
  assign dif.result       = result_r;
  assign dif.result_valid = result_valid_r;
  assign dif.result_err   = result_err_r;
  assign dif.roll_count   = roll_count_r;

endmodule
